// File: rtl/mbist_resp_analyzer.sv
// rtl/mbist_resp_analyzer.sv - MBIST response analyzer: read-latency alignment, compare, first-fail capture
//
// Purpose:
//   Follows the MBIST counter, tracks every read it issues to the SRAM, lines
//   up the expected data with rdata RD_LAT cycles later, counts mismatches
//   (saturating) and captures the first failing address/expected/actual value.
//   After cout is sampled, the in-flight reads are drained and done/pass are raised.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   cen, addr, data, we      counter outputs; a read carries its expected data on 'data'
//   cout                     counter overflow, end of test sequence
//   rdata                    SRAM read data, RD_LAT cycles after the read was issued
//   done, pass, fail         status (done sticky, pass valid with done, fail sticky)
//   err_cnt                  saturating mismatch count
//   fail_addr/exp/act        first mismatch capture
//   fail_bits                accumulated per-bit fail map
//
// Configuration:
//   MBIST_FAIL_BITMAP_EN     when defined, builds the fail_bits accumulator;
//                            otherwise fail_bits is tied to zero.

module mbist_resp_analyzer #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 4,
    parameter int RD_LAT    = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data,
    input  logic                 we,
    input  logic                 cout,
    input  logic [DATA_W-1:0]    rdata,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    fail_addr,
    output logic [DATA_W-1:0]    fail_exp,
    output logic [DATA_W-1:0]    fail_act,
    output logic [DATA_W-1:0]    fail_bits
);

    localparam int DCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [DCNT_W-1:0]             drain_cnt_q, drain_cnt_d;
    logic [RD_LAT-1:0]             vld_q, vld_d;
    logic [RD_LAT-1:0][ADDR_W-1:0] paddr_q, paddr_d;
    logic [RD_LAT-1:0][DATA_W-1:0] pexp_q, pexp_d;
    logic [ERR_CNT_W-1:0]          err_cnt_q, err_cnt_d;
    logic                          fail_q, fail_d;
    logic                          done_q, done_d;
    logic                          pass_q, pass_d;
    logic [ADDR_W-1:0]             fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]             fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0]             fail_act_q, fail_act_d;
    logic                          issue;
    logic                          mismatch;

    always_comb begin
        // A read enters the pipeline only while the counter is still running;
        // the cout cycle itself and anything after it are never tracked.
        issue    = cen && !we && !cout && (state_q == S_IDLE || state_q == S_RUN);
        mismatch = vld_q[RD_LAT-1] && (rdata != pexp_q[RD_LAT-1]);

        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cout) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else if (cen) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cout) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                // RD_LAT cycles covers the last read issued just before cout.
                if (drain_cnt_q == DCNT_W'(RD_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Pipeline shifts unconditionally so gaps in cen leave valid=0 holes.
        vld_d[0]   = issue;
        paddr_d[0] = addr;
        pexp_d[0]  = data;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            paddr_d[i] = paddr_q[i-1];
            pexp_d[i]  = pexp_q[i-1];
        end

        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        if (mismatch) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (!fail_q) begin
                fail_addr_d = paddr_q[RD_LAT-1];
                fail_exp_d  = pexp_q[RD_LAT-1];
                fail_act_d  = rdata;
            end
        end
        fail_d = fail_q | mismatch;
        done_d = done_q | (state_q == S_DONE);
        pass_d = done_d & ~fail_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            vld_q       <= '0;
            paddr_q     <= '0;
            pexp_q      <= '0;
            err_cnt_q   <= '0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            vld_q       <= vld_d;
            paddr_q     <= paddr_d;
            pexp_q      <= pexp_d;
            err_cnt_q   <= err_cnt_d;
            fail_q      <= fail_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
        end
    end

`ifdef MBIST_FAIL_BITMAP_EN
    logic [DATA_W-1:0] fail_bits_q, fail_bits_d;

    always_comb begin
        fail_bits_d = fail_bits_q;
        if (mismatch) begin
            fail_bits_d = fail_bits_q | (rdata ^ pexp_q[RD_LAT-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_bits_q <= '0;
        end else begin
            fail_bits_q <= fail_bits_d;
        end
    end

    assign fail_bits = fail_bits_q;
`else
    assign fail_bits = '0;
`endif

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign err_cnt   = err_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;

endmodule

// File: tb/tb_mbist_resp_analyzer.sv
// tb/tb_mbist_resp_analyzer.sv - scoreboard bench for mbist_resp_analyzer at read latencies 1 and 3

module tb_mbist_resp_analyzer;

    typedef struct {
        int         n;
        logic [7:0] addr;
        logic [3:0] exp;
        logic [3:0] act;
        logic [3:0] bits;
        int         cout_cyc;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       we = 1'b0;
    logic       cout = 1'b0;
    logic [7:0] addr = '0;
    logic [3:0] data = '0;
    logic [3:0] next_rd = '0;
    logic [3:0] rdata1 = '0;
    logic [2:0][3:0] rd3_pipe = '0;
    logic [3:0] rdata3;

    logic       done1, pass1, fail1, done3, pass3, fail3;
    logic [7:0] ec1, fa1, ec3, fa3;
    logic [3:0] fe1, fact1, fb1, fe3, fact3, fb3;

    logic [3:0] mem [256];
    logic [7:0] f_addr = '0;
    logic [3:0] f_s0 = '0;
    logic [3:0] f_s1 = '0;
    bit         f_inv = 1'b0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen [2];
    rec_t q0 [$];
    rec_t q1 [$];

    mbist_resp_analyzer #(.ADDR_W(8), .DATA_W(4), .RD_LAT(1), .ERR_CNT_W(8)) u_l1 (
        .clk(clk), .rst(rst), .cen(cen), .addr(addr), .data(data), .we(we), .cout(cout),
        .rdata(rdata1), .done(done1), .pass(pass1), .fail(fail1), .err_cnt(ec1),
        .fail_addr(fa1), .fail_exp(fe1), .fail_act(fact1), .fail_bits(fb1)
    );

    mbist_resp_analyzer #(.ADDR_W(8), .DATA_W(4), .RD_LAT(3), .ERR_CNT_W(8)) u_l3 (
        .clk(clk), .rst(rst), .cen(cen), .addr(addr), .data(data), .we(we), .cout(cout),
        .rdata(rdata3), .done(done3), .pass(pass3), .fail(fail3), .err_cnt(ec3),
        .fail_addr(fa3), .fail_exp(fe3), .fail_act(fact3), .fail_bits(fb3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rdata1   <= next_rd;
        rd3_pipe <= {rd3_pipe[1:0], next_rd};
    end
    assign rdata3 = rd3_pipe[2];

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d got %0h expected %0h at cyc %0d", nm, k, got, want, cyc);
        end
    endtask

    function automatic logic [3:0] sram_read(input logic [7:0] a);
        logic [3:0] v;
        v = mem[a];
        if (a == f_addr) v = (v & ~f_s0) | f_s1;
        if (f_inv) v = ~v;
        return v;
    endfunction

    task automatic mon(input int k, input logic dn, input logic ps, input logic fl,
                       input logic [7:0] ec, input logic [7:0] fa, input logic [3:0] fe,
                       input logic [3:0] fac, input logic [3:0] fb, input int lat);
        rec_t r;
        logic [3:0] wbits;
        if (!dn) begin
            chk("pass_without_done", k, {31'd0, ps}, 32'd0);
            if (seen[k]) chk("done_sticky", k, {31'd0, dn}, 32'd1);
        end else if (!seen[k]) begin
            seen[k] = 1'b1;
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done inst%0d got done=1 expected done=0 at cyc %0d", k, cyc);
            end else begin
                if (k == 0) r = q0.pop_front();
                else        r = q1.pop_front();
`ifdef MBIST_FAIL_BITMAP_EN
                wbits = r.bits;
`else
                wbits = 4'h0;
`endif
                chk("done_cycle", k, cyc, r.cout_cyc + lat + 1);
                chk("err_cnt", k, {24'd0, ec}, (r.n > 255) ? 255 : r.n);
                chk("pass", k, {31'd0, ps}, {31'd0, (r.n == 0)});
                chk("fail", k, {31'd0, fl}, {31'd0, (r.n != 0)});
                chk("fail_addr", k, {24'd0, fa}, {24'd0, r.addr});
                chk("fail_exp", k, {28'd0, fe}, {28'd0, r.exp});
                chk("fail_act", k, {28'd0, fac}, {28'd0, r.act});
                chk("fail_bits", k, {28'd0, fb}, {28'd0, wbits});
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                mon(0, done1, pass1, fail1, ec1, fa1, fe1, fact1, fb1, 1);
                mon(1, done3, pass3, fail3, ec3, fa3, fe3, fact3, fb3, 3);
            end
        end
    end

    task automatic step(input logic c, input logic w, input logic co,
                        input logic [7:0] a, input logic [3:0] d);
        @(negedge clk);
        cen  = c;
        we   = w;
        cout = co;
        addr = a;
        data = d;
        if (c && !w) next_rd = sram_read(a);
        else         next_rd = 4'($urandom);
        if (c && w) mem[a] = d;
    endtask

    // Reset with cout, cen and reads asserted and rdata disagreeing: all outputs must stay 0.
    task automatic reset_dut();
        @(negedge clk);
        rst     = 1'b1;
        cen     = 1'b1;
        we      = 1'b0;
        cout    = 1'b1;
        addr    = 8'($urandom);
        data    = 4'($urandom);
        next_rd = ~data;
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        q0.delete();
        q1.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_outputs", 0, {1'b0, done1, pass1, fail1, ec1, fa1, fe1, fact1, fb1}, 32'd0);
            chk("reset_outputs", 1, {1'b0, done3, pass3, fail3, ec3, fa3, fe3, fact3, fb3}, 32'd0);
        end
        @(negedge clk);
        rst  = 1'b0;
        cen  = 1'b0;
        cout = 1'b0;
    endtask

    // March-like sequence: write bg0, read bg0, write bg1, read bg1 over 256 addresses.
    task automatic run_test(input logic [3:0] bg0, input logic [3:0] bg1, input logic [7:0] fa,
                            input logic [3:0] s0, input logic [3:0] s1, input bit inv,
                            input int gap_pct, input int abort_at);
        rec_t       r;
        int         idx;
        logic [3:0] bg;
        logic [3:0] act;
        r = '{n: 0, addr: 8'h0, exp: 4'h0, act: 4'h0, bits: 4'h0, cout_cyc: 0};
        idx    = 0;
        f_addr = fa;
        f_s0   = s0;
        f_s1   = s1;
        f_inv  = inv;
        repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom), 1'b0, 8'($urandom), 4'($urandom));
        for (int ph = 0; ph < 4; ph++) begin
            for (int a = 0; a < 256; a++) begin
                bg = (ph < 2) ? bg0 : bg1;
                while (int'($urandom_range(0, 99)) < gap_pct)
                    step(1'b0, 1'($urandom), 1'b0, 8'($urandom), 4'($urandom));
                if (idx == abort_at) begin
                    reset_dut();
                    return;
                end
                idx++;
                if (ph % 2 == 1) begin
                    act = sram_read(8'(a));
                    if (act !== bg) begin
                        if (r.n == 0) begin
                            r.addr = 8'(a);
                            r.exp  = bg;
                            r.act  = act;
                        end
                        r.n++;
                        r.bits = r.bits | (act ^ bg);
                    end
                    step(1'b1, 1'b0, 1'b0, 8'(a), bg);
                end else begin
                    step(1'b1, 1'b1, 1'b0, 8'(a), bg);
                end
            end
        end
        // cout cycle looks like a read but must not be tracked
        step(1'b1, 1'b0, 1'b1, 8'h00, 4'($urandom));
        r.cout_cyc = cyc + 1;
        q0.push_back(r);
        q1.push_back(r);
        // keep read-like stimulus going through drain; none of it may be compared
        for (int i = 0; i < 30 && !(seen[0] && seen[1]); i++)
            step(1'b1, 1'b0, 1'b0, 8'($urandom), 4'($urandom));
        if (!(seen[0] && seen[1])) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got done1=%0b done3=%0b expected both 1", done1, done3);
        end
        reset_dut();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'($urandom);
        reset_dut();                                                  // T1
        run_test(4'h0, 4'hF, 8'h00, 4'h0, 4'h0, 1'b0, 0, -1);         // T2 clean
        run_test(4'h0, 4'hF, 8'h35, 4'h4, 4'h0, 1'b0, 0, -1);         // T3 stuck-at-0 bit 2
        run_test(4'h0, 4'hF, 8'h00, 4'h0, 4'h0, 1'b1, 0, -1);         // T4 every read inverted
        run_test(4'h0, 4'hF, 8'hFF, 4'h1, 4'h0, 1'b0, 0, -1);         // T5 last read fails
        run_test(4'h0, 4'hF, 8'h00, 4'h0, 4'h0, 1'b1, 10, 300);       // T6 abort with reads in flight
        run_test(4'($urandom), 4'($urandom), 8'h00, 4'h0, 4'h0, 1'b0, 15, -1);
        repeat (3)
            run_test(4'($urandom), 4'($urandom), 8'($urandom), 4'($urandom),
                     4'($urandom), 1'b0, 20, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
